cache_line_fill: RTL and testbench

Miss-handling controller that sits directly upstream of the direct-mapped cache array (256 lines × 16 words × 32 bits, 20-bit tag, 8-bit index, 4-bit word offset). It accepts single-word CPU read requests, performs a lookup in the array, and on a miss fetches the 16-word block from main memory one word per beat. It assembles the 512-bit line, writes it into the array with a one-cycle fill write, then returns the requested word to the CPU.

---
 rtl/cache_line_fill.sv | 108 ++++++++++
 tb/tb_cache_line_fill.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_fill.sv
// Miss-handling controller in front of a direct-mapped cache array: lookup, block fetch, line fill, word return.
// Optional feature: define LFC_VALID_TRACK_EN to keep a per-line valid vector that qualifies array hits.
module cache_line_fill #(
   parameter int WORDS  = 16,
   parameter int WORD_W = 32,
   parameter int LINES  = 256
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cpuReq,
   input  logic [31:0]               cpuAddr,
   output logic                      cpuReady,
   output logic                      cpuValid,
   output logic [WORD_W-1:0]         cpuData,
   output logic [31:0]               cacheAddr,
   output logic                      cacheRead,
   output logic [WORDS*WORD_W-1:0]   cacheLine,
   input  logic                      cacheHit,
   input  logic [WORD_W-1:0]         cacheData,
   output logic                      memReq,
   output logic [31:0]               memAddr,
   input  logic                      memAck,
   input  logic                      memValid,
   input  logic [WORD_W-1:0]         memData
);

   localparam int OFF_W = $clog2(WORDS);
   localparam int IDX_W = $clog2(LINES);

   typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, MEM_REQ, FILL, WRITE} state_t;

   state_t                         state;
   logic [OFF_W-1:0]               beatCnt;
   logic [WORDS-1:0][WORD_W-1:0]   line;
   logic                           hit;

`ifdef LFC_VALID_TRACK_EN
   logic [LINES-1:0]               valid;
   // A tag match on a line never filled since reset is not trusted.
   assign hit = cacheHit && valid[cacheAddr[OFF_W +: IDX_W]];
`else
   assign hit = cacheHit;
`endif

   assign cacheLine = line;
   assign cacheRead = (state != WRITE);
   assign cpuReady  = (state == IDLE);
   assign memReq    = (state == MEM_REQ);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cpuValid  <= 1'b0;
         cpuData   <= '0;
         cacheAddr <= '0;
         memAddr   <= '0;
         line      <= '0;
         beatCnt   <= '0;
`ifdef LFC_VALID_TRACK_EN
         valid     <= '0;
`endif
      end else begin
         cpuValid <= 1'b0;
         case (state)
            IDLE: begin
               if (cpuReq) begin
                  cacheAddr <= cpuAddr;
                  state     <= LOOKUP;
               end
            end
            LOOKUP: state <= CHECK;
            CHECK: begin
               if (hit) begin
                  cpuValid <= 1'b1;
                  cpuData  <= cacheData;
                  state    <= IDLE;
               end else begin
                  memAddr <= {cacheAddr[31:OFF_W], {OFF_W{1'b0}}};
                  state   <= MEM_REQ;
               end
            end
            MEM_REQ: begin
               if (memAck) begin
                  beatCnt <= '0;
                  state   <= FILL;
               end
            end
            FILL: begin
               if (memValid) begin
                  line[beatCnt] <= memData;
                  beatCnt       <= beatCnt + 1'b1;
                  if (beatCnt == OFF_W'(WORDS - 1)) state <= WRITE;
               end
            end
            WRITE: begin
               cpuValid <= 1'b1;
               cpuData  <= line[cacheAddr[OFF_W-1:0]];
`ifdef LFC_VALID_TRACK_EN
               valid[cacheAddr[OFF_W +: IDX_W]] <= 1'b1;
`endif
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed plus randomized bench for cache_line_fill, checked against a transaction-level reference model.
module tb_cache_line_fill;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cpuReq = 1'b0;
   logic [31:0]   cpuAddr = '0;
   logic          cpuReady, cpuValid;
   logic [31:0]   cpuData, cacheAddr, memAddr;
   logic          cacheRead, memReq;
   logic [511:0]  cacheLine;
   logic          cacheHit = 1'b0;
   logic [31:0]   cacheData = '0;
   logic          memAck = 1'b0, memValid = 1'b0;
   logic [31:0]   memData = '0;

   int nvec = 0;
   int nmis = 0;

`ifdef LFC_VALID_TRACK_EN
   localparam bit VT = 1'b1;
`else
   localparam bit VT = 1'b0;
`endif

   // Reference state: which lines have been filled since the last reset.
   bit [255:0]  vmodel;
   logic [31:0] beats [16];

   cache_line_fill dut (
      .clk(clk), .rst_n(rst_n), .cpuReq(cpuReq), .cpuAddr(cpuAddr),
      .cpuReady(cpuReady), .cpuValid(cpuValid), .cpuData(cpuData),
      .cacheAddr(cacheAddr), .cacheRead(cacheRead), .cacheLine(cacheLine),
      .cacheHit(cacheHit), .cacheData(cacheData),
      .memReq(memReq), .memAddr(memAddr), .memAck(memAck),
      .memValid(memValid), .memData(memData)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      vmodel = '0;
   endtask

   // One CPU read: returns through the hit path or the full miss path.
   task automatic txn(input logic [31:0] addr, input bit ahit, input logic [31:0] adata,
                      input int ack_dly, input int gapmode, input int rst_beat);
      logic [511:0] exp_line;
      logic [31:0]  base;
      bit           exp_hit;
      base    = {addr[31:4], 4'h0};
      exp_hit = ahit && (!VT || vmodel[addr[11:4]]);

      chk("ready_idle", cpuReady, 1'b1);
      cpuReq = 1'b1; cpuAddr = addr; cacheHit = ahit; cacheData = adata;
      tick();
      cpuReq = 1'b0; cpuAddr = $urandom;
      chk("lookup_addr", cacheAddr, addr);
      chk("lookup_read", cacheRead, 1'b1);
      chk("lookup_busy", cpuReady, 1'b0);
      tick();
      tick();
      if (exp_hit) begin
         chk("hit_valid", cpuValid, 1'b1);
         chk("hit_data", cpuData, adata);
         chk("hit_ready", cpuReady, 1'b1);
         chk("hit_nomem", memReq, 1'b0);
         tick();
         chk("hit_pulse", cpuValid, 1'b0);
         return;
      end

      chk("miss_req", memReq, 1'b1);
      chk("miss_memaddr", memAddr, base);
      chk("miss_novalid", cpuValid, 1'b0);
      for (int i = 0; i < ack_dly; i++) begin
         cpuReq = i[0]; cpuAddr = ~addr;
         memValid = 1'b1; memData = $urandom;
         tick();
         chk("wait_req", memReq, 1'b1);
         chk("wait_memaddr", memAddr, base);
         chk("wait_cacheaddr", cacheAddr, addr);
      end
      cpuReq = 1'b0;
      memAck = 1'b1; memValid = 1'b1; memData = 32'hDEAD_BEEF;
      tick();
      memAck = 1'b0; memValid = 1'b0;

      exp_line = '0;
      for (int k = 0; k < 16; k++) exp_line[32*k +: 32] = beats[k];

      for (int k = 0; k < 16; k++) begin
         if (gapmode == 1 || (gapmode == 2 && $urandom_range(0, 1) == 1)) begin
            memValid = 1'b0; memData = $urandom;
            tick();
            chk("gap_noearly", cacheRead, 1'b1);
         end
         memValid = 1'b1; memData = beats[k];
         if (k == rst_beat) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1; memValid = 1'b0;
            vmodel = '0;
            chk("rst_memreq", memReq, 1'b0);
            chk("rst_ready", cpuReady, 1'b1);
            chk("rst_valid", cpuValid, 1'b0);
            for (int s = 0; s < 3; s++) begin
               memValid = 1'b1; memData = $urandom;
               tick();
               chk("stray_ready", cpuReady, 1'b1);
               chk("stray_line", cacheLine, '0);
            end
            memValid = 1'b0;
            return;
         end
         tick();
         if (k < 15) chk("beat_noearly", cacheRead, 1'b1);
      end
      memValid = 1'b0;
      chk("write_read", cacheRead, 1'b0);
      chk("write_addr", cacheAddr, addr);
      chk("write_line", cacheLine, exp_line);
      chk("write_novalid", cpuValid, 1'b0);
      tick();
      vmodel[addr[11:4]] = 1'b1;
      chk("miss_valid", cpuValid, 1'b1);
      chk("miss_data", cpuData, beats[addr[3:0]]);
      chk("miss_ready", cpuReady, 1'b1);
      chk("miss_readback", cacheRead, 1'b1);
      tick();
      chk("miss_pulse", cpuValid, 1'b0);
   endtask

   task automatic rand_beats();
      for (int k = 0; k < 16; k++) beats[k] = $urandom;
   endtask

   initial begin
      logic [31:0] a;
      do_reset();
      chk("rst_ready0", cpuReady, 1'b1);
      chk("rst_valid0", cpuValid, 1'b0);
      chk("rst_data0", cpuData, '0);
      chk("rst_cacheaddr0", cacheAddr, '0);
      chk("rst_memaddr0", memAddr, '0);
      chk("rst_line0", cacheLine, '0);
      chk("rst_memreq0", memReq, 1'b0);
      chk("rst_read0", cacheRead, 1'b1);

      // Cold miss on 0x1234 with known beats 0xA0+k, then a warm hit.
      for (int k = 0; k < 16; k++) beats[k] = 32'hA0 + k;
      txn(32'h0000_1234, VT, 32'h0, 0, 0, -1);
      txn(32'h0000_1234, 1'b1, 32'hA4, 0, 0, -1);

      // Gapped burst with a stray beat on the ack cycle.
      rand_beats();
      txn(32'h0000_5678, 1'b0, 32'h0, 0, 1, -1);

      // Late ack with CPU requests and stray beats during the wait.
      rand_beats();
      txn(32'h00AB_CDE3, 1'b0, 32'h0, 5, 0, -1);

      // Reset during beat 7, then the same address must miss again.
      rand_beats();
      txn(32'h0000_9ABC, 1'b0, 32'h0, 2, 0, 7);
      rand_beats();
      txn(32'h0000_9ABC, VT, 32'h0, 0, 0, -1);

      // A fresh tag match right after reset: hit only without valid tracking.
      do_reset();
      rand_beats();
      txn(32'h0000_7770, 1'b1, 32'h1357_9BDF, 1, 0, -1);

      for (int t = 0; t < 24; t++) begin
         case ($urandom_range(0, 3))
            0: a = 32'h0000_1234;
            1: a = 32'h0000_5678;
            2: a = {20'h0, 8'h12, 4'($urandom)};
            default: a = $urandom;
         endcase
         rand_beats();
         txn(a, 1'($urandom), $urandom, $urandom_range(0, 4), 2, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
